mlsu_mctrl_seq: RTL and testbench
=================================

Name: mlsu_mctrl_seq

Overview:
Parametrised matrix control sequencer for the MLSU. It accepts one matrix load/store command with a one-hot layout mode: row-major, col-major, transpose or reshape. It walks the tile and emits one memory beat request per cycle, each covering up to NrLanes elements, with the byte address and destination tile coordinates. It sits between MLSU command decode and the address/data path, and replaces the stateless mode-decode helpers with a mode-aware address sequencer.

Parameters:
AddrWidth, 64, byte address and stride width
MaxDim, 64, maximum rows/cols of a tile
NrLanes, 4, maximum elements per beat (power of two)
DimW, $clog2(MaxDim+1), width of the rows/cols fields
IdxW, $clog2(MaxDim*MaxDim+1), width of coordinate/flat-index outputs

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_base_i  in  AddrWidth  tile base byte address
cmd_stride_i  in  AddrWidth  byte stride between outer lines
cmd_rows_i  in  DimW  tile rows
cmd_cols_i  in  DimW  tile cols
cmd_eew_i  in  2  element width, ebytes = 1<<eew
cmd_mode_i  in  4  one-hot mode: [0] row-major, [1] col-major, [2] transpose, [3] reshape
req_valid_o  out  1  beat request valid
req_ready_i  in  1  beat consumed when valid&ready
req_addr_o  out  AddrWidth  byte address of the beat's first element
req_row_o  out  IdxW  destination row of the first element
req_col_o  out  IdxW  destination col of the first element (flat index in reshape)
req_vert_o  out  1  beat elements run along destination rows
req_nelem_o  out  $clog2(NrLanes+1)  valid elements in the beat, 1..NrLanes
req_last_o  out  1  final beat of the command
done_o  out  1  one-cycle pulse on command completion
err_o  out  1  one-cycle pulse on an illegal mode
busy_o  out  1  high while not IDLE

Behaviour:
- States: IDLE, RUN, DONE. Reset enters IDLE. Reset values of all outputs: 0, except cmd_ready_o=1.
- IDLE: cmd_ready_o=1. On handshake, all command fields are registered.
  - Mode not one-hot (popcount != 1): next cycle err_o=1, stay IDLE, no beats.
  - rows==0 or cols==0: go to DONE, no beats.
  - Otherwise go to RUN. The first req_valid_o is asserted the cycle after acceptance.
- Inner length L and outer count O per mode:
  - row-major and transpose: L=cols, O=rows.
  - col-major: L=rows, O=cols.
  - reshape: L=rows*cols, O=1, stride ignored.
- Addresses:
  - Beat address = line_base + i*ebytes, where i is the inner index, stepped by NrLanes.
  - line_base starts at cmd_base_i and adds stride per outer step.
  - All address arithmetic wraps modulo 2^AddrWidth.
- req_nelem_o = min(NrLanes, L-i). The inner index wraps to 0 and the outer index increments after the beat where i+nelem==L.
- Coordinates, with o = outer index and i = inner index:
  - row-major: row=o, col=i, vert=0.
  - col-major: row=i, col=o, vert=1.
  - transpose: row=i, col=o, vert=1 (memory read row-major, written transposed).
  - reshape: row=0, col=i (flat index), vert=0.
- req_last_o=1 on the beat with o==O-1 and i+nelem==L.
- Handshake:
  - Outputs are stable while req_valid_o=1 and req_ready_i=0.
  - The request advances only on valid&ready.
  - Back-to-back beats are issued every cycle while ready is held high.
- Completion: the last handshake transitions to DONE. DONE asserts done_o for one cycle, then returns to IDLE.
  - cmd_ready_o is 0 in RUN and DONE. No command overlap.
- reset asserted mid-RUN: abort immediately, return to IDLE, drop req_valid_o, no done_o.
- Single-element tile (1x1): exactly one beat, with nelem=1 and last=1.

Test Plan:
1. Row-major, rows=2 cols=6 eew=2 base=0x1000 stride=0x100, NrLanes=4, ready=1 -> beats (0x1000,r0,c0,n4), (0x1010,r0,c4,n2), (0x1100,r1,c0,n4), (0x1110,r1,c4,n2,last); done_o one cycle later.
2. Col-major, rows=3 cols=2 eew=1 base=0x2000 stride=0x40 -> (0x2000,r0,c0,n3,vert), (0x2040,r0,c1,n3,vert,last).
3. Transpose with the same command as test 1 -> identical addresses; coordinates (r0,c0), (r4,c0), (r0,c1), (r4,c1), all vert=1.
4. Reshape, rows=3 cols=3 eew=0 base=0x10 stride=0xFFF -> (0x10,c0,n4), (0x14,c4,n4), (0x18,c8,n1,last).
5. Illegal mode 4'b0011 or 4'b0000 -> err_o pulse, zero beats, cmd_ready_o=1 again next cycle. Command with cols=0 -> done_o, zero beats.
6. Test 1 with req_ready_i low for 3 cycles on beat 2 -> beat fields held constant; reset mid-RUN -> req_valid_o=0 next cycle, no done_o, IDLE.

Source files
------------

// File: rtl/mlsu_mctrl_seq_if.sv
// Command and beat-request bundle for the MLSU matrix control sequencer.
// The master side issues commands and consumes beats; the slave side is the sequencer.
interface mlsu_mctrl_seq_if #(
  parameter int AddrWidth = 64,
  parameter int MaxDim    = 64,
  parameter int NrLanes   = 4
);
  localparam int DimW   = $clog2(MaxDim + 1);
  localparam int IdxW   = $clog2(MaxDim * MaxDim + 1);
  localparam int NelemW = $clog2(NrLanes + 1);

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [AddrWidth-1:0] cmd_base_i;
  logic [AddrWidth-1:0] cmd_stride_i;
  logic [DimW-1:0]      cmd_rows_i;
  logic [DimW-1:0]      cmd_cols_i;
  logic [1:0]           cmd_eew_i;
  logic [3:0]           cmd_mode_i;

  logic                 req_valid_o;
  logic                 req_ready_i;
  logic [AddrWidth-1:0] req_addr_o;
  logic [IdxW-1:0]      req_row_o;
  logic [IdxW-1:0]      req_col_o;
  logic                 req_vert_o;
  logic [NelemW-1:0]    req_nelem_o;
  logic                 req_last_o;

  logic                 done_o;
  logic                 err_o;
  logic                 busy_o;

  modport master (
    output cmd_valid_i, cmd_base_i, cmd_stride_i, cmd_rows_i, cmd_cols_i, cmd_eew_i, cmd_mode_i,
    output req_ready_i,
    input  cmd_ready_o, req_valid_o, req_addr_o, req_row_o, req_col_o, req_vert_o,
    input  req_nelem_o, req_last_o, done_o, err_o, busy_o
  );

  modport slave (
    input  cmd_valid_i, cmd_base_i, cmd_stride_i, cmd_rows_i, cmd_cols_i, cmd_eew_i, cmd_mode_i,
    input  req_ready_i,
    output cmd_ready_o, req_valid_o, req_addr_o, req_row_o, req_col_o, req_vert_o,
    output req_nelem_o, req_last_o, done_o, err_o, busy_o
  );
endinterface

// File: rtl/mlsu_mctrl_seq.sv
// Mode-aware matrix tile sequencer: walks one load/store command and emits one
// memory beat (up to NrLanes elements) per cycle with byte address and tile coordinates.
module mlsu_mctrl_seq #(
  parameter int AddrWidth = 64,
  parameter int MaxDim    = 64,
  parameter int NrLanes   = 4,
  parameter int DimW      = $clog2(MaxDim + 1),
  parameter int IdxW      = $clog2(MaxDim * MaxDim + 1)
) (
  input logic              clock,
  input logic              reset,
  mlsu_mctrl_seq_if.slave  bus
);
  localparam int NelemW = $clog2(NrLanes + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  function automatic logic is_onehot(input logic [3:0] m);
    return (m != 4'b0000) && ((m & (m - 4'b0001)) == 4'b0000);
  endfunction

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 req_valid_q, req_valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [3:0]           mode_q, mode_d;
  logic [1:0]           eew_q, eew_d;
  logic [AddrWidth-1:0] stride_q, stride_d;
  logic [AddrWidth-1:0] lbase_q, lbase_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [IdxW-1:0]      len_q, len_d;
  logic [DimW-1:0]      ocnt_q, ocnt_d;
  logic [IdxW-1:0]      i_q, i_d;
  logic [DimW-1:0]      o_q, o_d;
  logic [NelemW-1:0]    nelem_q, nelem_d;
  logic                 last_q, last_d;
  logic [IdxW-1:0]      row_q, row_d;
  logic [IdxW-1:0]      col_q, col_d;
  logic                 vert_q, vert_d;

  logic                 beat_upd_s;
  logic                 endl_s;
  logic [IdxW-1:0]      rem_s;
  logic [NelemW-1:0]    nelem_s;

  // Next-state, index stepping and next-beat attribute computation
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    req_valid_d = req_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy_q;
    mode_d      = mode_q;
    eew_d       = eew_q;
    stride_d    = stride_q;
    lbase_d     = lbase_q;
    addr_d      = addr_q;
    len_d       = len_q;
    ocnt_d      = ocnt_q;
    i_d         = i_q;
    o_d         = o_q;
    nelem_d     = nelem_q;
    last_d      = last_q;
    row_d       = row_q;
    col_d       = col_q;
    vert_d      = vert_q;
    beat_upd_s  = 1'b0;
    endl_s      = ((i_q + IdxW'(nelem_q)) == len_q);

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          mode_d   = bus.cmd_mode_i;
          eew_d    = bus.cmd_eew_i;
          stride_d = bus.cmd_stride_i;
          lbase_d  = bus.cmd_base_i;
          addr_d   = bus.cmd_base_i;
          i_d      = {IdxW{1'b0}};
          o_d      = {DimW{1'b0}};
          // Reshape flattens the tile into a single line; stride is unused
          if (bus.cmd_mode_i[3]) begin
            len_d  = IdxW'(bus.cmd_rows_i) * IdxW'(bus.cmd_cols_i);
            ocnt_d = DimW'(1);
          end else if (bus.cmd_mode_i[1]) begin
            len_d  = IdxW'(bus.cmd_rows_i);
            ocnt_d = bus.cmd_cols_i;
          end else begin
            len_d  = IdxW'(bus.cmd_cols_i);
            ocnt_d = bus.cmd_rows_i;
          end
          if (!is_onehot(bus.cmd_mode_i)) begin
            err_d = 1'b1;
          end else if ((bus.cmd_rows_i == {DimW{1'b0}}) || (bus.cmd_cols_i == {DimW{1'b0}})) begin
            state_d     = DONE;
            cmd_ready_d = 1'b0;
            busy_d      = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d     = RUN;
            cmd_ready_d = 1'b0;
            busy_d      = 1'b1;
            req_valid_d = 1'b1;
            beat_upd_s  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.req_ready_i) begin
          if (last_q) begin
            state_d     = DONE;
            req_valid_d = 1'b0;
            done_d      = 1'b1;
          end else if (endl_s) begin
            beat_upd_s = 1'b1;
            i_d        = {IdxW{1'b0}};
            o_d        = o_q + DimW'(1);
            lbase_d    = lbase_q + stride_q;
            addr_d     = lbase_q + stride_q;
          end else begin
            beat_upd_s = 1'b1;
            i_d        = i_q + IdxW'(NrLanes);
            addr_d     = addr_q + (AddrWidth'(NrLanes) << eew_q);
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        req_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

    rem_s = len_d - i_d;
    if (rem_s >= IdxW'(NrLanes)) begin
      nelem_s = NelemW'(NrLanes);
    end else begin
      nelem_s = rem_s[NelemW-1:0];
    end

    if (beat_upd_s) begin
      nelem_d = nelem_s;
      last_d  = (o_d == (ocnt_d - DimW'(1))) && ((i_d + IdxW'(nelem_s)) == len_d);
      case (mode_d)
        4'b0001: begin row_d = IdxW'(o_d);   col_d = i_d;         vert_d = 1'b0; end
        4'b0010: begin row_d = i_d;          col_d = IdxW'(o_d);  vert_d = 1'b1; end
        4'b0100: begin row_d = i_d;          col_d = IdxW'(o_d);  vert_d = 1'b1; end
        4'b1000: begin row_d = {IdxW{1'b0}}; col_d = i_d;         vert_d = 1'b0; end
        default: begin row_d = {IdxW{1'b0}}; col_d = {IdxW{1'b0}}; vert_d = 1'b0; end
      endcase
    end else begin
      nelem_d = nelem_q;
      last_d  = last_q;
      row_d   = row_q;
      col_d   = col_q;
      vert_d  = vert_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mode_q      <= 4'b0000;
      eew_q       <= 2'b00;
      stride_q    <= {AddrWidth{1'b0}};
      lbase_q     <= {AddrWidth{1'b0}};
      addr_q      <= {AddrWidth{1'b0}};
      len_q       <= {IdxW{1'b0}};
      ocnt_q      <= {DimW{1'b0}};
      i_q         <= {IdxW{1'b0}};
      o_q         <= {DimW{1'b0}};
      nelem_q     <= {NelemW{1'b0}};
      last_q      <= 1'b0;
      row_q       <= {IdxW{1'b0}};
      col_q       <= {IdxW{1'b0}};
      vert_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      req_valid_q <= req_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      eew_q       <= eew_d;
      stride_q    <= stride_d;
      lbase_q     <= lbase_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      ocnt_q      <= ocnt_d;
      i_q         <= i_d;
      o_q         <= o_d;
      nelem_q     <= nelem_d;
      last_q      <= last_d;
      row_q       <= row_d;
      col_q       <= col_d;
      vert_q      <= vert_d;
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.req_valid_o = req_valid_q;
  assign bus.req_addr_o  = addr_q;
  assign bus.req_row_o   = row_q;
  assign bus.req_col_o   = col_q;
  assign bus.req_vert_o  = vert_q;
  assign bus.req_nelem_o = nelem_q;
  assign bus.req_last_o  = last_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_mlsu_mctrl_seq.sv
// Bench for mlsu_mctrl_seq: command table, nested-loop beat model feeding a
// scoreboard queue, plus hand sequences for reset and mid-run abort.
module tb_mlsu_mctrl_seq;
  localparam int AW = 64;
  localparam int MD = 64;
  localparam int NL = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mlsu_mctrl_seq_if #(.AddrWidth(AW), .MaxDim(MD), .NrLanes(NL)) bus ();
  mlsu_mctrl_seq #(.AddrWidth(AW), .MaxDim(MD), .NrLanes(NL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  mode;
    int          rows;
    int          cols;
    logic [1:0]  eew;
    logic [63:0] base;
    logic [63:0] stride;
    int          exp_beats;
    bit          exp_err;
    int          stall_beat;
    int          stall_n;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    int          row;
    int          col;
    bit          vert;
    int          nelem;
    bit          last;
  } beat_t;

  beat_t sb[$];
  vec_t  vecs[14];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference walk: straightforward nested loops over outer lines and inner chunks
  task automatic model(input vec_t v);
    int len, outer, n;
    beat_t b;
    if (v.mode[3]) begin len = v.rows * v.cols; outer = 1; end
    else if (v.mode[1]) begin len = v.rows; outer = v.cols; end
    else begin len = v.cols; outer = v.rows; end
    for (int o = 0; o < outer; o++) begin
      for (int i = 0; i < len; i += NL) begin
        n = (len - i < NL) ? (len - i) : NL;
        b.addr  = v.base + (v.mode[3] ? 64'd0 : 64'(o) * v.stride) + (64'(i) << v.eew);
        b.nelem = n;
        b.last  = (o == outer - 1) && (i + n == len);
        if (v.mode[3]) begin b.row = 0; b.col = i; b.vert = 1'b0; end
        else if (v.mode[0]) begin b.row = o; b.col = i; b.vert = 1'b0; end
        else begin b.row = i; b.col = o; b.vert = 1'b1; end
        sb.push_back(b);
      end
    end
  endtask

  task automatic cmp_beat(input string tag, input beat_t e);
    check({tag, " addr"},  bus.req_addr_o,  e.addr);
    check({tag, " row"},   64'(bus.req_row_o),   64'(e.row));
    check({tag, " col"},   64'(bus.req_col_o),   64'(e.col));
    check({tag, " vert"},  64'(bus.req_vert_o),  64'(e.vert));
    check({tag, " nelem"}, 64'(bus.req_nelem_o), 64'(e.nelem));
    check({tag, " last"},  64'(bus.req_last_o),  64'(e.last));
  endtask

  task automatic drive_cmd(input vec_t v);
    bus.cmd_mode_i   = v.mode;
    bus.cmd_rows_i   = 7'(v.rows);
    bus.cmd_cols_i   = 7'(v.cols);
    bus.cmd_eew_i    = v.eew;
    bus.cmd_base_i   = v.base;
    bus.cmd_stride_i = v.stride;
    bus.cmd_valid_i  = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int beats = 0;
    int errs = 0;
    int dones = 0;
    int stall_left = v.stall_n;
    bit fin = 1'b0;
    if (!v.exp_err) model(v);
    @(negedge clock);
    check({tag, " idle ready"}, 64'(bus.cmd_ready_o), 64'd1);
    drive_cmd(v);
    bus.req_ready_i = 1'b1;
    @(negedge clock);
    bus.cmd_valid_i = 1'b0;
    check({tag, " first valid"}, 64'(bus.req_valid_o), 64'(v.exp_beats > 0));
    check({tag, " busy"}, 64'(bus.busy_o), 64'(!v.exp_err));
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (bus.err_o) errs++;
      if (bus.done_o) dones++;
      if (bus.req_valid_o) begin
        if (beats == v.stall_beat && stall_left > 0) begin
          bus.req_ready_i = 1'b0;
          stall_left--;
          if (sb.size() > 0) cmp_beat({tag, " held"}, sb[0]);
        end else begin
          bus.req_ready_i = 1'b1;
          if (sb.size() > 0) cmp_beat(tag, sb.pop_front());
          beats++;
        end
      end else begin
        bus.req_ready_i = 1'b1;
      end
      if (bus.err_o || bus.done_o) fin = 1'b1;
    end
    check({tag, " finished"}, 64'(fin), 64'd1);
    check({tag, " beats"}, 64'(beats), 64'(v.exp_beats));
    check({tag, " err pulses"}, 64'(errs), 64'(v.exp_err));
    check({tag, " done pulses"}, 64'(dones), 64'(!v.exp_err));
    check({tag, " sb empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clock);
    check({tag, " done cleared"}, 64'(bus.done_o), 64'd0);
    check({tag, " err cleared"}, 64'(bus.err_o), 64'd0);
    check({tag, " ready after"}, 64'(bus.cmd_ready_o), 64'd1);
    check({tag, " idle busy"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 2, 6, 2'd2, 64'h1000, 64'h100, 4, 1'b0, -1, 0};
    vecs[1]  = '{4'b0010, 3, 2, 2'd1, 64'h2000, 64'h40, 2, 1'b0, -1, 0};
    vecs[2]  = '{4'b0100, 2, 6, 2'd2, 64'h1000, 64'h100, 4, 1'b0, -1, 0};
    vecs[3]  = '{4'b1000, 3, 3, 2'd0, 64'h10, 64'hFFF, 3, 1'b0, -1, 0};
    vecs[4]  = '{4'b0011, 2, 2, 2'd0, 64'h0, 64'h10, 0, 1'b1, -1, 0};
    vecs[5]  = '{4'b0000, 2, 2, 2'd0, 64'h0, 64'h10, 0, 1'b1, -1, 0};
    vecs[6]  = '{4'b0001, 2, 0, 2'd0, 64'h500, 64'h10, 0, 1'b0, -1, 0};
    vecs[7]  = '{4'b0001, 1, 1, 2'd3, 64'h40, 64'h8, 1, 1'b0, -1, 0};
    vecs[8]  = '{4'b0001, 2, 6, 2'd2, 64'h1000, 64'h100, 4, 1'b0, 1, 3};
    vecs[9]  = '{4'b0010, 5, 3, 2'd3, 64'h3000, 64'h200, 6, 1'b0, -1, 0};
    vecs[10] = '{4'b0001, 2, 3, 2'd3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 2, 1'b0, -1, 0};
    vecs[11] = '{4'b1000, 64, 64, 2'd0, 64'h0, 64'h1, 1024, 1'b0, 5, 2};
    vecs[12] = '{4'b0100, 5, 7, 2'd1, 64'h8000, 64'h80, 10, 1'b0, 3, 1};
    vecs[13] = '{4'b1100, 3, 3, 2'd0, 64'h0, 64'h0, 0, 1'b1, -1, 0};

    bus.cmd_valid_i  = 1'b0;
    bus.cmd_mode_i   = 4'b0000;
    bus.cmd_rows_i   = 7'd0;
    bus.cmd_cols_i   = 7'd0;
    bus.cmd_eew_i    = 2'd0;
    bus.cmd_base_i   = 64'd0;
    bus.cmd_stride_i = 64'd0;
    bus.req_ready_i  = 1'b0;

    repeat (3) @(negedge clock);
    check("rst cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("rst req_valid", 64'(bus.req_valid_o), 64'd0);
    check("rst done", 64'(bus.done_o), 64'd0);
    check("rst err", 64'(bus.err_o), 64'd0);
    check("rst busy", 64'(bus.busy_o), 64'd0);
    check("rst addr", bus.req_addr_o, 64'd0);
    check("rst nelem", 64'(bus.req_nelem_o), 64'd0);
    check("rst last", 64'(bus.req_last_o), 64'd0);
    reset = 1'b0;

    for (int k = 0; k < 14; k++) run_vec(vecs[k], $sformatf("v%0d", k));

    // Abort a running command with reset: no done, back to idle
    @(negedge clock);
    drive_cmd(vecs[0]);
    bus.req_ready_i = 1'b1;
    @(negedge clock);
    bus.cmd_valid_i = 1'b0;
    @(negedge clock);
    check("abort mid valid", 64'(bus.req_valid_o), 64'd1);
    check("abort mid addr", bus.req_addr_o, 64'h1010);
    reset = 1'b1;
    @(negedge clock);
    check("abort valid", 64'(bus.req_valid_o), 64'd0);
    check("abort done", 64'(bus.done_o), 64'd0);
    check("abort busy", 64'(bus.busy_o), 64'd0);
    check("abort ready", 64'(bus.cmd_ready_o), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    check("abort no done", 64'(bus.done_o), 64'd0);
    check("abort idle valid", 64'(bus.req_valid_o), 64'd0);
    run_vec(vecs[1], "post-abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
